// File: rtl/if_id_inject_reg_pkg.sv
// Shared IF/ID types: widths, bubble encoding, injector opcodes, pipe state and ID register layout.
package pipe_pkg;
   localparam int INSTR_W = 16;
   localparam int PC_W    = 32;

   localparam logic [INSTR_W-1:0] NOP_INSTR      = 16'h0000;
   localparam logic [INSTR_W-1:0] POP_PC_HIGH_OP = 16'h6089;
   localparam logic [INSTR_W-1:0] POP_PC_LOW_OP  = 16'h6088;
   localparam logic [INSTR_W-1:0] POP_CCR_OP     = 16'hFFFF;

   typedef enum logic [1:0] {PASS, INJECT, HOLD} pipe_state_e;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
      logic               valid;
      logic               injected;
   } id_reg_t;
endpackage

// File: rtl/if_id_inject_reg_if.sv
// Fetch/injector/hazard inputs and decode-side outputs of the IF/ID register.
interface if_id_inject_reg_if;
   import pipe_pkg::*;

   logic [INSTR_W-1:0] fetch_instr;
   logic [PC_W-1:0]    fetch_pc;
   logic               fetch_valid;
   logic [INSTR_W-1:0] inj_instr;
   logic               inj_stall;
   logic               hazard_stall;
   logic               flush;
   logic [INSTR_W-1:0] id_instr;
   logic [PC_W-1:0]    id_pc;
   logic               id_valid;
   logic               id_injected;
   logic               pc_hold;

   modport master (
      output fetch_instr, fetch_pc, fetch_valid, inj_instr, inj_stall, hazard_stall, flush,
      input  id_instr, id_pc, id_valid, id_injected, pc_hold
   );
   modport slave (
      input  fetch_instr, fetch_pc, fetch_valid, inj_instr, inj_stall, hazard_stall, flush,
      output id_instr, id_pc, id_valid, id_injected, pc_hold
   );
endinterface

// File: rtl/if_id_inject_reg_skid.sv
// One-entry instr+pc skid buffer; a write while full is ignored unless the entry drains the same cycle.
module skid_buf1 import pipe_pkg::*; (
   input  logic               clk,
   input  logic               reset,
   input  logic               clr,
   input  logic               wr,
   input  logic               rd,
   input  logic [INSTR_W-1:0] wr_instr,
   input  logic [PC_W-1:0]    wr_pc,
   output logic [INSTR_W-1:0] rd_instr,
   output logic [PC_W-1:0]    rd_pc,
   output logic               full
);
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         full <= 1'b0;
      end else if (wr && (!full || rd)) begin
         rd_instr <= wr_instr;
         rd_pc    <= wr_pc;
         full     <= 1'b1;
      end else if (rd) begin
         full <= 1'b0;
      end
   end
endmodule

// File: rtl/if_id_inject_reg.sv
// IF/ID register muxing fetch vs injected micro-ops, with a 1-entry skid for the in-flight fetch.
// Optional IF_ID_BUBBLE_CNT_EN adds a saturating bubble/injection cycle counter output.
module if_id_inject_reg import pipe_pkg::*; (
   input  logic               clk,
   input  logic               reset,
   if_id_inject_reg_if.slave  bus
`ifdef IF_ID_BUBBLE_CNT_EN
   , output logic [15:0]      bubble_cnt
`endif
);
   pipe_state_e        state_q, state_d;
   id_reg_t            id_q, id_d;
   logic               skid_wr, skid_rd, skid_clr, skid_full;
   logic [INSTR_W-1:0] skid_instr;
   logic [PC_W-1:0]    skid_pc;

   skid_buf1 u_skid (
      .clk      (clk),
      .reset    (reset),
      .clr      (skid_clr),
      .wr       (skid_wr),
      .rd       (skid_rd),
      .wr_instr (bus.fetch_instr),
      .wr_pc    (bus.fetch_pc),
      .rd_instr (skid_instr),
      .rd_pc    (skid_pc),
      .full     (skid_full)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= PASS;
         id_q    <= '{instr: NOP_INSTR, pc: '0, valid: 1'b0, injected: 1'b0};
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
      end
   end

   always_comb begin
      state_d  = PASS;
      id_d     = id_q;
      skid_wr  = 1'b0;
      skid_rd  = 1'b0;
      skid_clr = 1'b0;
      if (bus.inj_stall) begin
         // injected micro-ops commit even under flush; only the younger fetch is dropped
         state_d     = INJECT;
         id_d.instr    = bus.inj_instr;
         id_d.valid    = 1'b1;
         id_d.injected = 1'b1;
         skid_clr      = bus.flush;
         skid_wr       = bus.fetch_valid & ~bus.flush;
      end else if (bus.flush) begin
         id_d.instr    = NOP_INSTR;
         id_d.valid    = 1'b0;
         id_d.injected = 1'b0;
         skid_clr      = 1'b1;
      end else if (bus.hazard_stall) begin
         state_d = HOLD;
         skid_wr = bus.fetch_valid;
      end else begin
         id_d.injected = 1'b0;
         if (skid_full) begin
            // drain the older entry; a live fetch refills behind it
            id_d.instr = skid_instr;
            id_d.pc    = skid_pc;
            id_d.valid = 1'b1;
            skid_rd    = 1'b1;
            skid_wr    = bus.fetch_valid;
         end else if (bus.fetch_valid) begin
            id_d.instr = bus.fetch_instr;
            id_d.pc    = bus.fetch_pc;
            id_d.valid = 1'b1;
         end else begin
            id_d.instr = NOP_INSTR;
            id_d.valid = 1'b0;
         end
      end
   end

   assign bus.id_instr    = id_q.instr;
   assign bus.id_pc       = id_q.pc;
   assign bus.id_valid    = id_q.valid;
   assign bus.id_injected = id_q.injected;
   assign bus.pc_hold     = ~reset & (bus.inj_stall | bus.hazard_stall | skid_full);

`ifdef IF_ID_BUBBLE_CNT_EN
   always_ff @(posedge clk) begin
      if (reset)
         bubble_cnt <= '0;
      else if ((!id_q.valid || id_q.injected) && bubble_cnt != 16'hFFFF)
         bubble_cnt <= bubble_cnt + 16'd1;
   end
`endif

   a_skid_overflow: assert property (@(posedge clk) disable iff (reset)
      !(skid_wr && skid_full && !skid_rd));
   a_inject_commits: assert property (@(posedge clk) disable iff (reset)
      (state_q == INJECT) |-> (id_q.valid && id_q.injected));
endmodule
